// File: rtl/food_placer_if.sv
// food_placer_if: bundles the placement request, randomizer candidate, grid RAM
// read/write ports and status outputs of food_placer.
//   PlaceReq            request a new food placement
//   CandV/CandH         free-running randomizer candidate
//   RdV/RdH, RdData     grid RAM read port (RAM registers the address)
//   WrEn/WrV/WrH/WrData grid RAM write port
//   FoodV/FoodH         last committed food position
//   Busy/Done/Fail      status; Done and Fail are single-cycle pulses
// Modports: master = environment side, slave = food_placer side.
interface food_placer_if #(
    parameter int unsigned GRID_WIDTH     = 16,
    parameter int unsigned GRID_HEIGHT    = 16,
    parameter int unsigned BITS_PER_BLOCK = 2
);
    localparam int unsigned HW = $clog2(GRID_HEIGHT);
    localparam int unsigned WW = $clog2(GRID_WIDTH);

    logic                      PlaceReq;
    logic [HW-1:0]             CandV;
    logic [WW-1:0]             CandH;
    logic [HW-1:0]             RdV;
    logic [WW-1:0]             RdH;
    logic [BITS_PER_BLOCK-1:0] RdData;
    logic                      WrEn;
    logic [HW-1:0]             WrV;
    logic [WW-1:0]             WrH;
    logic [BITS_PER_BLOCK-1:0] WrData;
    logic [HW-1:0]             FoodV;
    logic [WW-1:0]             FoodH;
    logic                      Busy;
    logic                      Done;
    logic                      Fail;

    modport master (
        output PlaceReq, CandV, CandH, RdData,
        input  RdV, RdH, WrEn, WrV, WrH, WrData, FoodV, FoodH, Busy, Done, Fail
    );

    modport slave (
        input  PlaceReq, CandV, CandH, RdData,
        output RdV, RdH, WrEn, WrV, WrH, WrData, FoodV, FoodH, Busy, Done, Fail
    );
endinterface

// File: rtl/food_placer.sv
// food_placer: places a food block on the game grid. Random candidates from the
// randomizer are checked for being interior and empty; after MAX_TRIES rejects the
// placement is exhausted.
// Ports:
//   MasterClock  sole clock, rising edge
//   Reset        synchronous, active-high
//   bus          food_placer_if.slave (request, candidate, grid RAM ports, status)
// Configuration macro FOOD_SCAN_FALLBACK_EN: when defined, exhaustion falls back to a
// raster scan of the interior from (1,1); when undefined, exhaustion pulses Fail.
module food_placer #(
    parameter int unsigned GRID_WIDTH     = 16,
    parameter int unsigned GRID_HEIGHT    = 16,
    parameter int unsigned BITS_PER_BLOCK = 2,
    parameter int unsigned BLOCK_EMPTY    = 0,
    parameter int unsigned BLOCK_FOOD     = 3,
    parameter int unsigned MAX_TRIES      = 8
) (
    input logic          MasterClock,
    input logic          Reset,
    food_placer_if.slave bus
);
    localparam int unsigned HW = $clog2(GRID_HEIGHT);
    localparam int unsigned WW = $clog2(GRID_WIDTH);
    localparam logic [HW-1:0] VMax   = HW'(GRID_HEIGHT - 2);
    localparam logic [WW-1:0] HMax   = WW'(GRID_WIDTH - 2);
    localparam logic [7:0]    TryMax = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StCheck,
        StWrite
`ifdef FOOD_SCAN_FALLBACK_EN
        , StScanRd,
        StScanChk
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] cur_v_q, cur_v_d;
    logic [WW-1:0] cur_h_q, cur_h_d;
    logic [7:0]    try_q, try_d;
    logic [HW-1:0] wr_v_q, wr_v_d, food_v_q, food_v_d;
    logic [WW-1:0] wr_h_q, wr_h_d, food_h_q, food_h_d;
    logic          fail_q, fail_d;
`ifdef FOOD_SCAN_FALLBACK_EN
    logic [HW-1:0] scan_v_q, scan_v_d;
    logic [WW-1:0] scan_h_q, scan_h_d;
`endif

    logic       interior;
    logic       rd_empty;
    logic [7:0] try_inc;
    logic       reject;

    assign interior = (cur_v_q >= HW'(1)) && (cur_v_q <= VMax) &&
                      (cur_h_q >= WW'(1)) && (cur_h_q <= HMax);
    assign rd_empty = (bus.RdData == BITS_PER_BLOCK'(BLOCK_EMPTY));
    assign try_inc  = try_q + 8'd1;

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state_q  <= StIdle;
            cur_v_q  <= '0;
            cur_h_q  <= '0;
            try_q    <= '0;
            wr_v_q   <= '0;
            wr_h_q   <= '0;
            food_v_q <= '0;
            food_h_q <= '0;
            fail_q   <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_v_q <= '0;
            scan_h_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cur_v_q  <= cur_v_d;
            cur_h_q  <= cur_h_d;
            try_q    <= try_d;
            wr_v_q   <= wr_v_d;
            wr_h_q   <= wr_h_d;
            food_v_q <= food_v_d;
            food_h_q <= food_h_d;
            fail_q   <= fail_d;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_v_q <= scan_v_d;
            scan_h_q <= scan_h_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_v_d  = cur_v_q;
        cur_h_d  = cur_h_q;
        try_d    = try_q;
        wr_v_d   = wr_v_q;
        wr_h_d   = wr_h_q;
        food_v_d = food_v_q;
        food_h_d = food_h_q;
        fail_d   = 1'b0;
        reject   = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_v_d = scan_v_q;
        scan_h_d = scan_h_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.PlaceReq) begin
                    cur_v_d = bus.CandV;
                    cur_h_d = bus.CandH;
                    try_d   = '0;
                    state_d = StSample;
                end
            end
            StSample: begin
                if (interior) state_d = StCheck;
                else          reject  = 1'b1;
            end
            StCheck: begin
                // RdData here answers the address presented during SAMPLE.
                if (rd_empty) begin
                    wr_v_d   = cur_v_q;
                    wr_h_d   = cur_h_q;
                    food_v_d = cur_v_q;
                    food_h_d = cur_h_q;
                    state_d  = StWrite;
                end else begin
                    reject = 1'b1;
                end
            end
            StWrite: state_d = StIdle;
`ifdef FOOD_SCAN_FALLBACK_EN
            StScanRd: state_d = StScanChk;
            StScanChk: begin
                if (rd_empty) begin
                    wr_v_d   = scan_v_q;
                    wr_h_d   = scan_h_q;
                    food_v_d = scan_v_q;
                    food_h_d = scan_h_q;
                    state_d  = StWrite;
                end else if (scan_v_q == VMax && scan_h_q == HMax) begin
                    fail_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (scan_h_q == HMax) begin
                        scan_h_d = WW'(1);
                        scan_v_d = scan_v_q + HW'(1);
                    end else begin
                        scan_h_d = scan_h_q + WW'(1);
                    end
                    state_d = StScanRd;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (reject) begin
            try_d = try_inc;
            if (try_inc == TryMax) begin
`ifdef FOOD_SCAN_FALLBACK_EN
                scan_v_d = HW'(1);
                scan_h_d = WW'(1);
                state_d  = StScanRd;
`else
                fail_d  = 1'b1;
                state_d = StIdle;
`endif
            end else begin
                // Candidate changes every cycle, so recapture a fresh one.
                cur_v_d = bus.CandV;
                cur_h_d = bus.CandH;
                state_d = StSample;
            end
        end
    end

`ifdef FOOD_SCAN_FALLBACK_EN
    assign bus.RdV = (state_q == StScanRd) ? scan_v_q : cur_v_q;
    assign bus.RdH = (state_q == StScanRd) ? scan_h_q : cur_h_q;
`else
    assign bus.RdV = cur_v_q;
    assign bus.RdH = cur_h_q;
`endif
    assign bus.WrEn   = (state_q == StWrite);
    assign bus.Done   = (state_q == StWrite);
    assign bus.WrV    = wr_v_q;
    assign bus.WrH    = wr_h_q;
    assign bus.WrData = BITS_PER_BLOCK'(BLOCK_FOOD);
    assign bus.FoodV  = food_v_q;
    assign bus.FoodH  = food_h_q;
    assign bus.Busy   = (state_q != StIdle);
    assign bus.Fail   = fail_q;
endmodule
